// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
// State codes are plain localparams so older netlists and probes keep matching.
package if_stage_pkg;

  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_pkt_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bundle: redirect/stall from the pipeline, instruction memory
// handshake, and the IF/ID pipeline register outputs.
interface if_stage_if;

  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rsp_vld;
  logic [31:0] imem_rsp_data;
  logic [31:0] IF_ID_pc;
  logic [31:0] IF_ID_inst;
  logic        IF_ID_vld;

  modport master (
    input  stall, br_taken, br_target, imem_rsp_vld, imem_rsp_data,
    output imem_req, imem_addr, IF_ID_pc, IF_ID_inst, IF_ID_vld
  );

  modport slave (
    output stall, br_taken, br_target, imem_rsp_vld, imem_rsp_data,
    input  imem_req, imem_addr, IF_ID_pc, IF_ID_inst, IF_ID_vld
  );

endinterface

// File: rtl/if_stage_skid_buf.sv
// One-entry {pc,inst} holding slot for a response that lands while decode
// is stalled on a live instruction.
module if_skid_buf
  import if_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       load,
  input  logic       unload,
  input  fetch_pkt_t din,
  output logic       vld,
  output fetch_pkt_t dout
);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld <= 1'b0;
    end else if (load) begin
      vld <= 1'b1;
    end else if (unload) begin
      vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else if (load) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding fetch FSM feeding a registered
// IF/ID stage, with branch redirect/flush and stale-response draining.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input logic        clk,
  input logic        rst,
  if_stage_if.master bus
);

  logic [1:0]  state;
  logic [31:0] pc_q;
  logic [31:0] req_pc;
  logic [31:0] if_id_pc_q;
  logic [31:0] if_id_inst_q;
  logic        if_id_vld_q;
  logic        buf_vld;
  fetch_pkt_t  buf_pkt;
  fetch_pkt_t  rsp_pkt;
  logic        imem_req;
  logic        hold;
  logic        rsp_take;
  logic        to_buf;
  logic        from_buf;

  assign hold     = if_id_vld_q && bus.stall;
  assign imem_req = !rst && (state == ST_FETCH) && !buf_vld && !hold && !bus.br_taken;
  assign rsp_take = (state == ST_WAIT) && bus.imem_rsp_vld && !bus.br_taken;
  assign to_buf   = rsp_take && hold;
  assign from_buf = !rsp_take && if_id_vld_q && !bus.stall && buf_vld;

  assign rsp_pkt.pc   = req_pc;
  assign rsp_pkt.inst = bus.imem_rsp_data;

  assign bus.imem_req   = imem_req;
  assign bus.imem_addr  = pc_q;
  assign bus.IF_ID_pc   = if_id_pc_q;
  assign bus.IF_ID_inst = if_id_inst_q;
  assign bus.IF_ID_vld  = if_id_vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_FETCH;
      pc_q   <= RESET_PC;
      req_pc <= RESET_PC;
    end else if (bus.br_taken) begin
      pc_q <= word_align(bus.br_target);
      // A response landing with the redirect closes the outstanding slot, so
      // neither WAIT nor DRAIN is left waiting for a reply that never comes.
      if (state != ST_FETCH && bus.imem_rsp_vld) begin
        state <= ST_FETCH;
      end else if (state == ST_WAIT) begin
        state <= ST_DRAIN;
      end
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_req) begin
            req_pc <= pc_q;
            state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.imem_rsp_vld) begin
            pc_q  <= req_pc + 32'd4;
            state <= ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (bus.imem_rsp_vld) begin
            state <= ST_FETCH;
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_vld_q  <= 1'b0;
      if_id_pc_q   <= 32'h0000_0000;
      if_id_inst_q <= NOP_INST;
    end else if (bus.br_taken) begin
      if_id_vld_q  <= 1'b0;
      if_id_inst_q <= NOP_INST;
    end else if (rsp_take && !hold) begin
      if_id_vld_q  <= 1'b1;
      if_id_pc_q   <= req_pc;
      if_id_inst_q <= bus.imem_rsp_data;
    end else if (from_buf) begin
      if_id_pc_q   <= buf_pkt.pc;
      if_id_inst_q <= buf_pkt.inst;
    end else if (if_id_vld_q && !bus.stall) begin
      if_id_vld_q  <= 1'b0;
      if_id_inst_q <= NOP_INST;
    end
  end

  if_skid_buf u_skid (
    .clk    (clk),
    .rst    (rst),
    .flush  (bus.br_taken),
    .load   (to_buf),
    .unload (from_buf),
    .din    (rsp_pkt),
    .vld    (buf_vld),
    .dout   (buf_pkt)
  );

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: queue-based fetch model checked every
// cycle, directed redirect/reset/stall scenarios, then randomized traffic.
module tb_if_stage;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] WRAP_RPC = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_stage_if bus ();
  if_stage_if wbus ();

  if_stage u_dut (.clk(clk), .rst(rst), .bus(bus));
  if_stage #(.RESET_PC(WRAP_RPC)) u_wrap (.clk(clk), .rst(rst), .bus(wbus));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_en = 0;

  // memory models: pending responses (due cycle, data)
  int          mq_due[$];
  logic [31:0] mq_dat[$];
  int          wq_due[$];
  logic [31:0] wq_dat[$];
  int          lat_min = 1;
  int          lat_max = 1;
  bit          rand_data = 0;

  // fetch model: presented/queued instructions plus one outstanding request
  logic [63:0] m_q[$];
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_req_pc = 32'h0;
  bit          m_out = 0;
  bit          m_stale = 0;

  logic [31:0] wlog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s cyc=%0d timed out waiting for DUT", name, cyc);
  endtask

  task automatic cycle_begin();
    @(posedge clk);
    #1;
    cyc++;
    if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
      bus.imem_rsp_vld  = 1'b1;
      bus.imem_rsp_data = mq_dat.pop_front();
      void'(mq_due.pop_front());
    end else begin
      bus.imem_rsp_vld  = 1'b0;
      bus.imem_rsp_data = $urandom;
    end
    if (wq_due.size() > 0 && wq_due[0] <= cyc) begin
      wbus.imem_rsp_vld  = 1'b1;
      wbus.imem_rsp_data = wq_dat.pop_front();
      void'(wq_due.pop_front());
    end else begin
      wbus.imem_rsp_vld  = 1'b0;
      wbus.imem_rsp_data = $urandom;
    end
  endtask

  task automatic cycle_end();
    bit          exp_req;
    logic [63:0] head;
    @(negedge clk);
    if (bus.imem_req === 1'b1) begin
      mq_due.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
      mq_dat.push_back(rand_data ? $urandom : bus.imem_addr);
    end
    if (wbus.imem_req === 1'b1) begin
      wq_due.push_back(cyc + 1);
      wq_dat.push_back(wbus.imem_addr);
    end
    if (chk_en && wbus.IF_ID_vld === 1'b1 && wlog.size() < 2) wlog.push_back(wbus.IF_ID_pc);

    exp_req = !rst && !m_out && m_q.size() < 2 && !(m_q.size() > 0 && bus.stall)
              && !bus.br_taken;
    if (chk_en) begin
      chk("imem_req", bus.imem_req, exp_req);
      if (exp_req) chk("imem_addr", bus.imem_addr, m_pc);
      chk("IF_ID_vld", bus.IF_ID_vld, m_q.size() > 0);
      if (m_q.size() > 0) begin
        head = m_q[0];
        chk("IF_ID_pc", bus.IF_ID_pc, head[63:32]);
        chk("IF_ID_inst", bus.IF_ID_inst, head[31:0]);
      end else begin
        chk("IF_ID_inst_nop", bus.IF_ID_inst, NOP);
      end
    end

    if (rst) begin
      m_q.delete();
      m_out   = 0;
      m_stale = 0;
      m_pc    = 32'h0;
      chk_en  = 1;
    end else if (bus.br_taken) begin
      m_q.delete();
      m_pc = bus.br_target & 32'hFFFF_FFFC;
      if (m_out) begin
        if (bus.imem_rsp_vld) m_out = 0;
        else m_stale = 1;
      end
    end else begin
      if (m_q.size() > 0 && !bus.stall) void'(m_q.pop_front());
      if (m_out && bus.imem_rsp_vld) begin
        if (!m_stale) begin
          m_q.push_back({m_req_pc, bus.imem_rsp_data});
          m_pc = m_req_pc + 32'd4;
        end
        m_out   = 0;
        m_stale = 0;
      end
      if (exp_req) begin
        m_out    = 1;
        m_stale  = 0;
        m_req_pc = m_pc;
      end
    end
  endtask

  task automatic tick();
    cycle_begin();
    cycle_end();
  endtask

  task automatic wait_req(input string name, output logic [31:0] addr);
    addr = 32'h0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.imem_req === 1'b1) begin
        addr = bus.imem_addr;
        return;
      end
    end
    timeout(name);
  endtask

  task automatic wait_vld(input string name, output logic [31:0] pc, output logic [31:0] inst);
    pc = 32'h0;
    inst = 32'h0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.IF_ID_vld === 1'b1) begin
        pc = bus.IF_ID_pc;
        inst = bus.IF_ID_inst;
        return;
      end
    end
    timeout(name);
  endtask

  initial begin
    logic [31:0] a, pc, inst;
    logic [31:0] vpc[3];
    logic [31:0] vinst[3];
    int          vcyc[3];
    int          n;

    bus.stall = 0;  bus.br_taken = 0;  bus.br_target = 0;
    wbus.stall = 0; wbus.br_taken = 0; wbus.br_target = 0;
    bus.imem_rsp_vld = 0;  bus.imem_rsp_data = 0;
    wbus.imem_rsp_vld = 0; wbus.imem_rsp_data = 0;

    // reset, then latency-1 memory echoing the address
    tick();
    tick();
    chk("rst_vld", bus.IF_ID_vld, 0);
    chk("rst_inst", bus.IF_ID_inst, NOP);
    chk("rst_req", bus.imem_req, 0);
    cycle_begin();
    rst = 0;
    cycle_end();
    chk("first_req", bus.imem_req, 1);
    chk("first_addr", bus.imem_addr, 32'h0);
    n = 0;
    for (int i = 0; i < 40 && n < 3; i++) begin
      tick();
      if (bus.IF_ID_vld === 1'b1) begin
        vpc[n] = bus.IF_ID_pc;
        vinst[n] = bus.IF_ID_inst;
        vcyc[n] = cyc;
        n++;
      end
    end
    if (n < 3) timeout("seq_vld");
    else begin
      chk("seq_pc0", vpc[0], 32'h0);   chk("seq_inst0", vinst[0], 32'h0);
      chk("seq_pc1", vpc[1], 32'h4);   chk("seq_inst1", vinst[1], 32'h4);
      chk("seq_pc2", vpc[2], 32'h8);   chk("seq_inst2", vinst[2], 32'h8);
      chk("seq_gap1", vcyc[1] - vcyc[0], 2);
      chk("seq_gap2", vcyc[2] - vcyc[1], 2);
    end

    // stall raised as a response lands: instruction held, no fetch
    lat_min = 2; lat_max = 2;
    wait_req("stall_req", a);
    tick();
    cycle_begin();
    bus.stall = 1;
    cycle_end();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_vld", bus.IF_ID_vld, 1);
      chk("stall_pc", bus.IF_ID_pc, a);
      chk("stall_req", bus.imem_req, 0);
    end
    cycle_begin();
    bus.stall = 0;
    cycle_end();
    chk("unstall_req", bus.imem_req, 1);
    chk("unstall_addr", bus.imem_addr, a + 32'd4);
    wait_vld("unstall_vld", pc, inst);
    chk("unstall_pc", pc, a + 32'd4);

    // redirect while waiting on a latency-3 fetch
    lat_min = 3; lat_max = 3;
    wait_req("drain_req", a);
    cycle_begin();
    bus.br_taken = 1;
    bus.br_target = 32'h100;
    cycle_end();
    cycle_begin();
    bus.br_taken = 0;
    cycle_end();
    chk("drain_vld", bus.IF_ID_vld, 0);
    chk("drain_req", bus.imem_req, 0);
    wait_req("drain_next", a);
    chk("drain_addr", a, 32'h100);
    wait_vld("drain_vld2", pc, inst);
    chk("drain_pc", pc, 32'h100);
    chk("drain_inst", inst, 32'h100);

    // redirect coinciding with the response, unaligned target
    lat_min = 2; lat_max = 2;
    wait_req("coin_req", a);
    tick();
    cycle_begin();
    bus.br_taken = 1;
    bus.br_target = 32'h203;
    cycle_end();
    cycle_begin();
    bus.br_taken = 0;
    cycle_end();
    chk("coin_vld", bus.IF_ID_vld, 0);
    chk("coin_inst", bus.IF_ID_inst, NOP);
    chk("coin_req", bus.imem_req, 1);
    chk("coin_addr", bus.imem_addr, 32'h200);

    // reset while a request is outstanding; its reply arrives after release
    lat_min = 3; lat_max = 3;
    wait_req("rstw_req", a);
    cycle_begin();
    rst = 1;
    cycle_end();
    chk("rstw_req_low", bus.imem_req, 0);
    tick();
    cycle_begin();
    rst = 0;
    cycle_end();
    chk("rstw_stale_vld", bus.imem_rsp_vld, 1);
    chk("rstw_req", bus.imem_req, 1);
    chk("rstw_addr", bus.imem_addr, 32'h0);
    wait_vld("rstw_vld", pc, inst);
    chk("rstw_pc", pc, 32'h0);
    chk("rstw_inst", inst, 32'h0);

    // randomized traffic
    lat_min = 1; lat_max = 4; rand_data = 1;
    for (int i = 0; i < 4000; i++) begin
      cycle_begin();
      rst = ($urandom_range(0, 249) == 0);
      bus.stall = ($urandom_range(0, 99) < 30);
      bus.br_taken = ($urandom_range(0, 99) < 6);
      bus.br_target = $urandom;
      cycle_end();
    end
    cycle_begin();
    rst = 0; bus.stall = 0; bus.br_taken = 0;
    cycle_end();

    if (wlog.size() < 2) timeout("wrap_seq");
    else begin
      chk("wrap_pc0", wlog[0], WRAP_RPC);
      chk("wrap_pc1", wlog[1], 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
